// File: rtl/signed_db_to_linear_gain_pkg.sv
// Shared definitions for the dB-to-linear gain stage: dB limits, octave offset,
// data widths, FSM state encoding, request payload and the mantissa ROM.
package signed_db_to_linear_gain_pkg;

   localparam int DB_MIN = -72;
   localparam int DB_MAX = 18;
   localparam int K_OFS  = 12;

   localparam int unsigned FRAC_BITS = 12;
   localparam int unsigned SAMPLE_W  = 12;
   localparam int unsigned DB_W      = 9;
   localparam int unsigned GAIN_W    = 16;
   localparam int unsigned U_W       = 7;   // u = dB - DB_MIN, 0..90
   localparam int unsigned Q_W       = 4;   // octave count, 0..15
   localparam int unsigned MANT_W    = 13;
   localparam int unsigned PROD_W    = SAMPLE_W + GAIN_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLAMP,
      ST_DIV,
      ST_SCALE,
      ST_MUL
   } state_e;

   typedef struct packed {
      logic signed [DB_W-1:0]     db;
      logic signed [SAMPLE_W-1:0] sample;
   } gain_req_t;

   // round(10^(r/20) * 4096) for the residual dB within one 6 dB octave
   function automatic logic [MANT_W-1:0] mant_lookup(input logic [2:0] r);
      logic [MANT_W-1:0] m;
      case (r)
         3'd0:    m = MANT_W'(4096);
         3'd1:    m = MANT_W'(4596);
         3'd2:    m = MANT_W'(5157);
         3'd3:    m = MANT_W'(5786);
         3'd4:    m = MANT_W'(6492);
         3'd5:    m = MANT_W'(7284);
         default: m = MANT_W'(4096);
      endcase
      return m;
   endfunction

endpackage

// File: rtl/signed_db_to_linear_gain_if.sv
// Request/response bus of the dB-to-linear gain stage.
//  start/input_db/input_sample : request, driven by the master
//  output_gain/output_sample/done : response, driven by the slave
interface signed_db_to_linear_gain_if;
   import signed_db_to_linear_gain_pkg::*;

   logic                       start;
   logic signed [DB_W-1:0]     input_db;
   logic signed [SAMPLE_W-1:0] input_sample;
   logic [GAIN_W-1:0]          output_gain;
   logic signed [SAMPLE_W-1:0] output_sample;
   logic                       done;

   modport master (
      output start, input_db, input_sample,
      input  output_gain, output_sample, done
   );

   modport slave (
      input  start, input_db, input_sample,
      output output_gain, output_sample, done
   );

endinterface

// File: rtl/db_divmod6.sv
// Sequential divide-by-6: one subtract step per cycle after a start pulse.
//  clk, rst : clock, async active-high reset
//  start    : load u_in into the remainder and clear the quotient
//  u_in     : dividend (0..90)
//  busy     : division in progress (stays set until the remainder drops below 6)
//  q, rem   : running quotient and remainder
module db_divmod6
   import signed_db_to_linear_gain_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [U_W-1:0] u_in,
   output logic           busy,
   output logic [Q_W-1:0] q,
   output logic [U_W-1:0] rem
);

   localparam logic [U_W-1:0] DIVISOR = U_W'(6);

   logic           busy_q, busy_d;
   logic [Q_W-1:0] q_q, q_d;
   logic [U_W-1:0] rem_q, rem_d;

   // Load on start, otherwise take one restoring step per cycle while busy
   always_comb begin
      busy_d = busy_q;
      q_d    = q_q;
      rem_d  = rem_q;
      if (start) begin
         busy_d = 1'b1;
         q_d    = '0;
         rem_d  = u_in;
      end else if (busy_q) begin
         if (rem_q >= DIVISOR) begin
            rem_d = rem_q - DIVISOR;
            q_d   = q_q + Q_W'(1);
         end else begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= 1'b0;
         q_q    <= '0;
         rem_q  <= '0;
      end else begin
         busy_q <= busy_d;
         q_q    <= q_d;
         rem_q  <= rem_d;
      end
   end

   assign busy = busy_q;
   assign q    = q_q;
   assign rem  = rem_q;

endmodule

// File: rtl/signed_db_to_linear_gain.sv
// Converts a signed integer dB gain into a Q4.12 linear multiplier (6 dB per
// octave plus a 6-entry mantissa ROM) and applies it to a 12-bit sample with
// saturation.
//  clk, rst : clock, async active-high reset
//  bus      : slave side; start/input_db/input_sample in,
//             output_gain/output_sample/done out (all registered)
module signed_db_to_linear_gain
   import signed_db_to_linear_gain_pkg::*;
(
   input logic                      clk,
   input logic                      rst,
   signed_db_to_linear_gain_if.slave bus
);

   localparam logic signed [DB_W-1:0] DB_MIN_S = DB_W'(DB_MIN);
   localparam logic signed [DB_W-1:0] DB_MAX_S = DB_W'(DB_MAX);
   localparam logic [Q_W-1:0]         K_OFS_U  = Q_W'(K_OFS);
   localparam logic [U_W-1:0]         REM_LIM  = U_W'(6);
   localparam int                     SAT_HI   = int'(2 ** (SAMPLE_W - 1)) - 1;
   localparam int                     SAT_LO   = -SAT_HI - 1;
   localparam logic signed [PROD_W-1:0] SAT_HI_P = PROD_W'(SAT_HI);
   localparam logic signed [PROD_W-1:0] SAT_LO_P = PROD_W'(SAT_LO);

   state_e                     state_q, state_d;
   gain_req_t                  req_q, req_d;
   logic [GAIN_W-1:0]          gain_q, gain_d;
   logic signed [SAMPLE_W-1:0] out_q, out_d;
   logic                       done_q, done_d;

   logic                       div_start_c;
   logic [U_W-1:0]             div_u_c;
   logic                       div_busy;
   logic [Q_W-1:0]             div_q;
   logic [U_W-1:0]             div_rem;

   logic signed [DB_W-1:0]     db_clamp_c;
   logic [MANT_W-1:0]          mant_c;
   logic [GAIN_W-1:0]          scaled_gain_c;
   logic signed [PROD_W-1:0]   prod_c;
   logic signed [PROD_W-1:0]   shifted_c;
   logic signed [SAMPLE_W-1:0] sat_c;

   db_divmod6 u_divmod6 (
      .clk   (clk),
      .rst   (rst),
      .start (div_start_c),
      .u_in  (div_u_c),
      .busy  (div_busy),
      .q     (div_q),
      .rem   (div_rem)
   );

   // Clamp the captured dB value and offset it so the divider sees 0..90
   always_comb begin
      if (req_q.db < DB_MIN_S) begin
         db_clamp_c = DB_MIN_S;
      end else if (req_q.db > DB_MAX_S) begin
         db_clamp_c = DB_MAX_S;
      end else begin
         db_clamp_c = req_q.db;
      end
      div_u_c = U_W'(db_clamp_c - DB_MIN_S);
   end

   // Mantissa shifted by k = q - K_OFS octaves; right shifts truncate
   always_comb begin
      mant_c = mant_lookup(div_rem[2:0]);
      if (div_q >= K_OFS_U) begin
         scaled_gain_c = GAIN_W'(mant_c) << (div_q - K_OFS_U);
      end else begin
         scaled_gain_c = GAIN_W'(mant_c) >> (K_OFS_U - div_q);
      end
   end

   // Signed sample times unsigned Q4.12 gain, floored back to integer and saturated
   always_comb begin
      prod_c    = PROD_W'($signed(req_q.sample)) * PROD_W'($signed({1'b0, gain_q}));
      shifted_c = prod_c >>> FRAC_BITS;
      if (shifted_c > SAT_HI_P) begin
         sat_c = SAMPLE_W'(SAT_HI);
      end else if (shifted_c < SAT_LO_P) begin
         sat_c = SAMPLE_W'(SAT_LO);
      end else begin
         sat_c = SAMPLE_W'(shifted_c);
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      gain_d      = gain_q;
      out_d       = out_q;
      done_d      = 1'b0;
      div_start_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               req_d.db     = bus.input_db;
               req_d.sample = bus.input_sample;
               state_d      = ST_CLAMP;
            end
         end
         ST_CLAMP: begin
            div_start_c = 1'b1;
            state_d     = ST_DIV;
         end
         ST_DIV: begin
            // The divider finishes on the same edge that its remainder is below 6
            if (div_busy && (div_rem < REM_LIM)) begin
               state_d = ST_SCALE;
            end
         end
         ST_SCALE: begin
            gain_d  = scaled_gain_c;
            state_d = ST_MUL;
         end
         ST_MUL: begin
            out_d   = sat_c;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
         gain_q  <= '0;
         out_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         gain_q  <= gain_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   assign bus.output_gain   = gain_q;
   assign bus.output_sample = out_q;
   assign bus.done          = done_q;

endmodule

// File: tb/tb_signed_db_to_linear_gain.sv
// Scoreboard bench for signed_db_to_linear_gain: stimulus pushes expected
// results from a real-arithmetic model, a negedge monitor pops and compares.
module tb_signed_db_to_linear_gain;

   logic clk;
   logic rst;

   signed_db_to_linear_gain_if bus ();

   signed_db_to_linear_gain dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      int     gain;
      int     sample;
      longint due;
   } exp_t;

   exp_t   sb[$];
   int     n_checks;
   int     n_fail;
   longint cycle_cnt;
   int     last_sample;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle_cnt++;

   // Behavioural model: 6 dB per octave, mantissa from 10^(r/20), floor division
   function automatic void model(input int db, input int sample,
                                 output int gain, output int outs, output int lat);
      int     dbc;
      int     u;
      int     q;
      int     r;
      int     mant;
      int     k;
      longint p;
      longint s;
      dbc = db;
      if (dbc < -72) dbc = -72;
      if (dbc > 18)  dbc = 18;
      u    = dbc + 72;
      q    = u / 6;
      r    = u % 6;
      mant = $rtoi((10.0 ** (r / 20.0)) * 4096.0 + 0.5);
      k    = q - 12;
      if (k >= 0) gain = mant * (1 << k);
      else        gain = mant / (1 << (-k));
      p = longint'(sample) * longint'(gain);
      if (p >= 0) s = p / 4096;
      else        s = -((-p + 4095) / 4096);
      if (s > 2047)  s = 2047;
      if (s < -2048) s = -2048;
      outs = int'(s);
      lat  = q + 4;
   endfunction

   // Assumes the caller is at a negedge; drives a one-cycle start pulse
   task automatic drive_start(input int db, input int sample, input bit push);
      exp_t e;
      int   g;
      int   o;
      int   lat;
      bus.input_db     = 9'(db);
      bus.input_sample = 12'(sample);
      bus.start        = 1'b1;
      if (push) begin
         model(db, sample, g, o, lat);
         e.gain   = g;
         e.sample = o;
         e.due    = cycle_cnt + 1 + longint'(lat);
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic issue(input int db, input int sample, input int gap);
      @(negedge clk);
      drive_start(db, sample, 1'b1);
      repeat (gap) @(negedge clk);
   endtask

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Monitor: compare each done against the scoreboard, otherwise check the sample holds
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.done) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 expected no pending result at cycle %0d",
                        cycle_cnt);
            end else begin
               e = sb.pop_front();
               check("gain", int'(bus.output_gain), e.gain);
               check("sample", int'(bus.output_sample), e.sample);
               check("latency", int'(cycle_cnt), int'(e.due));
               last_sample = e.sample;
            end
         end else begin
            check("hold_sample", int'(bus.output_sample), last_sample);
         end
      end
   end

   initial begin
      int wait_cnt;
      n_checks     = 0;
      n_fail       = 0;
      cycle_cnt    = 0;
      last_sample  = 0;
      bus.start        = 1'b0;
      bus.input_db     = '0;
      bus.input_sample = '0;
      rst = 1'b1;
      @(negedge clk);
      check("reset_gain", int'(bus.output_gain), 0);
      check("reset_sample", int'(bus.output_sample), 0);
      check("reset_done", int'(bus.done), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Directed points including clamp and floor boundaries
      issue(0, 1000, 30);
      issue(-6, 1000, 30);
      issue(-3, 1000, 30);
      issue(18, 2047, 30);
      issue(18, -2048, 30);
      issue(100, 2047, 30);
      issue(-100, 2047, 30);
      issue(-100, -2047, 30);
      issue(-72, 5, 30);
      issue(17, 300, 30);

      // Start during an operation is ignored; result belongs to the first operands
      @(negedge clk);
      drive_start(-3, 1000, 1'b1);
      repeat (2) @(negedge clk);
      drive_start(18, -2000, 1'b0);
      repeat (30) @(negedge clk);

      // Start in the done cycle is accepted
      @(negedge clk);
      drive_start(6, 800, 1'b1);
      wait_cnt = 0;
      while (!bus.done && wait_cnt < 40) begin
         @(negedge clk);
         wait_cnt++;
      end
      check("done_seen_for_back_to_back", int'(bus.done), 1);
      drive_start(0, 1234, 1'b1);
      repeat (30) @(negedge clk);

      // Reset in the middle of DIV clears outputs at once and suppresses done
      @(negedge clk);
      drive_start(0, 1000, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midop_reset_gain", int'(bus.output_gain), 0);
      check("midop_reset_sample", int'(bus.output_sample), 0);
      check("midop_reset_done", int'(bus.done), 0);
      last_sample = 0;
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (30) @(negedge clk);
      issue(-12, 1500, 30);

      // Randomized operands across and beyond the clamp range
      for (int i = 0; i < 200; i++) begin
         issue(int'($urandom_range(0, 260)) - 130,
               int'($urandom_range(0, 4095)) - 2048, 22);
      end

      wait_cnt = 0;
      while (sb.size() != 0 && wait_cnt < 100) begin
         @(negedge clk);
         wait_cnt++;
      end
      check("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
